// File: rtl/lamp_conflict_monitor.sv
// Safety monitor between the traffic light controller and the physical lamps.
// Detects conflicting, dark, multi-lit and mis-sequenced lamps and forces a latched yellow flash.
module lamp_conflict_monitor #(
  parameter int unsigned FILTER_CYCLES     = 4,
  parameter int unsigned FLASH_HALF        = 8,
  parameter int unsigned MIN_YELLOW_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       main_red,
  input  logic       main_yellow,
  input  logic       main_green,
  input  logic       side_red,
  input  logic       side_yellow,
  input  logic       side_green,
  input  logic       clr_fault,
  output logic       lamp_main_red,
  output logic       lamp_main_yellow,
  output logic       lamp_main_green,
  output logic       lamp_side_red,
  output logic       lamp_side_yellow,
  output logic       lamp_side_green,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] fault_count
);

  typedef enum logic [1:0] {StPass, StFault, StRecover} state_e;
  typedef enum logic [1:0] {LampUnk, LampRed, LampYellow, LampGreen} lamp_e;

  localparam logic [7:0]  FilterMax = 8'(FILTER_CYCLES);
  localparam logic [15:0] FlashLast = 16'(FLASH_HALF - 1);
  localparam logic [15:0] MinYellow = 16'(MIN_YELLOW_CYCLES);
  localparam logic [5:0]  AllRed    = 6'b100_100;

  state_e      state_q, state_d;
  logic [5:0]  raw, in_q, lamps;
  logic [1:0][2:0] road;
  logic [7:0]  filt_q, filt_d, rec_q, rec_d;
  logic [15:0] flash_cnt_q, flash_cnt_d;
  logic        flash_on_q, flash_on_d;
  logic [2:0]  code_q, code_d;
  logic [7:0]  count_q, count_d;
  lamp_e       trk_q [2];
  lamp_e       trk_d [2];
  logic [15:0] ycnt_q [2];
  logic [15:0] ycnt_d [2];

  logic        both_g, dark, multi, static_any, static_fire, all_red, recover_done;
  logic [2:0]  static_code, seq_code, det_code;
  logic        seq4, seq5;

  function automatic logic is_multi(input logic [2:0] x);
    return (x & (x - 3'd1)) != 3'd0;
  endfunction

  function automatic lamp_e lamp_of(input logic [2:0] x);
    case (x)
      3'b100:  return LampRed;
      3'b010:  return LampYellow;
      3'b001:  return LampGreen;
      default: return LampUnk;
    endcase
  endfunction

  function automatic logic legal_step(input lamp_e from, input lamp_e to);
    return (from == LampRed && to == LampGreen) || (from == LampGreen && to == LampYellow) ||
           (from == LampYellow && to == LampRed);
  endfunction

  assign raw     = {main_red, main_yellow, main_green, side_red, side_yellow, side_green};
  assign road    = {raw[2:0], raw[5:3]};  // road[0] is main, road[1] is side
  assign all_red = (raw == AllRed);

  // Static checks share one persistence filter that saturates at FILTER_CYCLES.
  always_comb begin
    both_g      = main_green & side_green;
    dark        = (road[0] == 3'd0) || (road[1] == 3'd0);
    multi       = is_multi(road[0]) || is_multi(road[1]);
    static_code = both_g ? 3'd1 : dark ? 3'd2 : multi ? 3'd3 : 3'd0;
    static_any  = (static_code != 3'd0);
    if (!static_any) begin
      filt_d = 8'd0;
    end else if (filt_q < FilterMax) begin
      filt_d = filt_q + 8'd1;
    end else begin
      filt_d = filt_q;
    end
    static_fire  = static_any && (({1'b0, filt_q} + 9'd1) >= {1'b0, FilterMax});
    recover_done = (state_q == StRecover) && !static_fire && all_red &&
                   (({1'b0, rec_q} + 9'd1) >= {1'b0, FilterMax});
  end

  always_comb begin
    lamp_e cur;
    seq4   = 1'b0;
    seq5   = 1'b0;
    trk_d  = trk_q;
    ycnt_d = ycnt_q;
    cur    = LampUnk;
    for (int r = 0; r < 2; r++) begin
      cur = lamp_of(road[r]);
      if (trk_q[r] == LampYellow && ycnt_q[r] != 16'hFFFF) begin
        ycnt_d[r] = ycnt_q[r] + 16'd1;
      end
      if (cur != LampUnk) begin
        if (trk_q[r] != LampUnk && cur != trk_q[r]) begin
          if (!legal_step(trk_q[r], cur)) begin
            seq4 = 1'b1;
          end else if (trk_q[r] == LampYellow && ycnt_q[r] < MinYellow) begin
            seq5 = 1'b1;
          end
        end
        trk_d[r] = cur;
        if (cur != LampYellow) begin
          ycnt_d[r] = 16'd0;
        end else if (trk_q[r] != LampYellow) begin
          ycnt_d[r] = 16'd1;
        end
      end
    end
    // Trackers are frozen while recovering and restart from scratch on return to PASS.
    if (state_q == StRecover) begin
      trk_d  = trk_q;
      ycnt_d = ycnt_q;
      if (recover_done) begin
        for (int r = 0; r < 2; r++) begin
          trk_d[r]  = LampUnk;
          ycnt_d[r] = 16'd0;
        end
      end
    end
  end

  assign seq_code = (state_q != StPass) ? 3'd0 : seq4 ? 3'd4 : seq5 ? 3'd5 : 3'd0;
  assign det_code = static_fire ? static_code : seq_code;

  always_comb begin
    logic enter;
    enter       = 1'b0;
    state_d     = state_q;
    code_d      = code_q;
    count_d     = count_q;
    rec_d       = 8'd0;
    flash_cnt_d = 16'd0;
    flash_on_d  = 1'b1;
    if (state_q != StPass) begin
      flash_on_d = flash_on_q;
      if (flash_cnt_q == FlashLast) begin
        flash_on_d = ~flash_on_q;
      end else begin
        flash_cnt_d = flash_cnt_q + 16'd1;
      end
    end
    unique case (state_q)
      StPass: begin
        enter = (det_code != 3'd0);
      end
      StFault: begin
        if (det_code == 3'd0 && clr_fault) begin
          state_d = StRecover;
        end
      end
      StRecover: begin
        if (det_code != 3'd0) begin
          enter = 1'b1;
        end else if (recover_done) begin
          state_d = StPass;
          code_d  = 3'd0;
        end else if (all_red) begin
          rec_d = rec_q + 8'd1;
        end
      end
      default: state_d = StPass;
    endcase
    if (enter) begin
      state_d     = StFault;
      code_d      = det_code;
      count_d     = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
      flash_cnt_d = 16'd0;
      flash_on_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StPass;
      in_q        <= AllRed;
      filt_q      <= 8'd0;
      rec_q       <= 8'd0;
      flash_cnt_q <= 16'd0;
      flash_on_q  <= 1'b1;
      code_q      <= 3'd0;
      count_q     <= 8'd0;
      for (int r = 0; r < 2; r++) begin
        trk_q[r]  <= LampUnk;
        ycnt_q[r] <= 16'd0;
      end
    end else begin
      state_q     <= state_d;
      in_q        <= raw;
      filt_q      <= filt_d;
      rec_q       <= rec_d;
      flash_cnt_q <= flash_cnt_d;
      flash_on_q  <= flash_on_d;
      code_q      <= code_d;
      count_q     <= count_d;
      for (int r = 0; r < 2; r++) begin
        trk_q[r]  <= trk_d[r];
        ycnt_q[r] <= ycnt_d[r];
      end
    end
  end

  always_comb begin
    if (state_q == StPass) begin
      lamps = in_q;
    end else begin
      lamps = {1'b0, flash_on_q, 1'b0, 1'b0, flash_on_q, 1'b0};
    end
  end

  assign {lamp_main_red, lamp_main_yellow, lamp_main_green} = lamps[5:3];
  assign {lamp_side_red, lamp_side_yellow, lamp_side_green} = lamps[2:0];
  assign fault       = (state_q != StPass);
  assign fault_code  = code_q;
  assign fault_count = count_q;

endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// Directed and randomized checks of lamp_conflict_monitor against a cycle-level reference model.
module tb_lamp_conflict_monitor;
  localparam int F  = 4;
  localparam int H  = 8;
  localparam int MY = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] drv = 6'b100_100;
  logic       clr = 1'b0;
  wire  [5:0] lamps_w;
  wire        fault_w;
  wire  [2:0] code_w;
  wire  [7:0] count_w;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: state 0 pass, 1 fault, 2 recover; lamp ids 0 unknown, 1 R, 2 Y, 3 G.
  int         m_state, m_filt, m_rec, m_code, m_count, m_t;
  int         m_last [2];
  int         m_ylen [2];
  logic [5:0] m_reg;
  int         nxt [4] = '{0, 3, 1, 2};

  lamp_conflict_monitor #(.FILTER_CYCLES(F), .FLASH_HALF(H), .MIN_YELLOW_CYCLES(MY)) dut (
    .clk(clk), .rst(rst),
    .main_red(drv[5]), .main_yellow(drv[4]), .main_green(drv[3]),
    .side_red(drv[2]), .side_yellow(drv[1]), .side_green(drv[0]),
    .clr_fault(clr),
    .lamp_main_red(lamps_w[5]), .lamp_main_yellow(lamps_w[4]), .lamp_main_green(lamps_w[3]),
    .lamp_side_red(lamps_w[2]), .lamp_side_yellow(lamps_w[1]), .lamp_side_green(lamps_w[0]),
    .fault(fault_w), .fault_code(code_w), .fault_count(count_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lamp_id(input logic [2:0] x);
    case (x)
      3'b100:  return 1;
      3'b010:  return 2;
      3'b001:  return 3;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_filt = 0; m_rec = 0; m_code = 0; m_count = 0; m_t = 0;
    m_reg = 6'b100_100;
    for (int r = 0; r < 2; r++) begin
      m_last[r] = 0;
      m_ylen[r] = 0;
    end
  endtask

  task automatic model_step(input logic [5:0] in, input logic c);
    logic [2:0] rd [2];
    int  stat, det, prev, cur, n;
    bit  fire, s4, s5, enter, all_red;
    rd[0] = in[5:3];
    rd[1] = in[2:0];
    if (in[3] && in[0]) stat = 1;
    else if (rd[0] == 0 || rd[1] == 0) stat = 2;
    else if ($countones(rd[0]) > 1 || $countones(rd[1]) > 1) stat = 3;
    else stat = 0;
    m_filt = (stat != 0) ? m_filt + 1 : 0;
    fire = (stat != 0) && (m_filt >= F);
    s4 = 0;
    s5 = 0;
    for (int r = 0; r < 2; r++) begin
      n   = $countones(rd[r]);
      cur = lamp_id(rd[r]);
      if (m_state == 0 && n == 1 && m_last[r] != 0 && cur != m_last[r]) begin
        if (cur != nxt[m_last[r]]) s4 = 1;
        else if (m_last[r] == 2 && m_ylen[r] < MY) s5 = 1;
      end
      if (m_state != 2) begin
        if (n == 1) begin
          m_ylen[r] = (cur != 2) ? 0 : (m_last[r] == 2) ? m_ylen[r] + 1 : 1;
          m_last[r] = cur;
        end else if (m_last[r] == 2) begin
          m_ylen[r]++;
        end
      end
    end
    det = fire ? stat : s4 ? 4 : s5 ? 5 : 0;
    all_red = (in == 6'b100_100);
    prev  = m_state;
    enter = 0;
    case (m_state)
      0: enter = (det != 0);
      1: if (det == 0 && c) m_state = 2;
      default: begin
        if (fire) enter = 1;
        else if (all_red && m_rec + 1 >= F) begin
          m_state = 0;
          m_code  = 0;
          for (int r = 0; r < 2; r++) begin
            m_last[r] = 0;
            m_ylen[r] = 0;
          end
        end
      end
    endcase
    m_rec = (prev == 2 && m_state == 2 && !enter && all_red) ? m_rec + 1 : 0;
    if (enter) begin
      m_state = 1;
      m_code  = det;
      m_count = (m_count < 255) ? m_count + 1 : 255;
      m_t     = 0;
    end else if (prev != 0 && m_state != 0) begin
      m_t++;
    end
    m_reg = in;
  endtask

  task automatic compare_all();
    logic [5:0] exp_l;
    logic       ph;
    ph    = ((m_t / H) % 2) == 0;
    exp_l = (m_state == 0) ? m_reg : {1'b0, ph, 1'b0, 1'b0, ph, 1'b0};
    chk("lamps", 32'(lamps_w), 32'(exp_l));
    chk("fault", 32'(fault_w), 32'(m_state != 0));
    chk("fault_code", 32'(code_w), 32'(m_code));
    chk("fault_count", 32'(count_w), 32'(m_count));
  endtask

  task automatic cyc(input logic [5:0] in, input logic c);
    drv = in;
    clr = c;
    @(posedge clk);
    model_step(in, c);
    #1;
    clr = 1'b0;
    compare_all();
  endtask

  task automatic run(input logic [5:0] in, input int n);
    repeat (n) cyc(in, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_lamps"}, 32'(lamps_w), 32'(6'b100_100));
    chk({tag, "_fault"}, 32'(fault_w), 32'd0);
    chk({tag, "_code"}, 32'(code_w), 32'd0);
    chk({tag, "_count"}, 32'(count_w), 32'd0);
  endtask

  initial begin
    logic [5:0] pat;
    logic [5:0] pats [10] = '{6'b100_100, 6'b001_100, 6'b010_100, 6'b100_001, 6'b100_010,
                              6'b001_001, 6'b000_100, 6'b110_100, 6'b100_100, 6'b001_010};
    model_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    // Legal cycle with a 2-cycle Y+R overlap on main.
    run(6'b100_100, 3);
    run(6'b001_100, 30);
    run(6'b010_100, 23);
    run(6'b110_100, 2);
    run(6'b100_100, 3);
    run(6'b100_001, 30);
    run(6'b100_010, 25);
    run(6'b100_100, 3);
    chk("legal_fault", 32'(fault_w), 32'd0);

    // Both greens for only 3 cycles, then a legal side yellow.
    run(6'b001_001, 3);
    chk("bg3_fault", 32'(fault_w), 32'd0);
    run(6'b001_010, 20);
    run(6'b001_100, 2);
    chk("bg3_after", 32'(fault_w), 32'd0);

    // Main green straight to red.
    run(6'b100_100, 1);
    chk("g2r_fault", 32'(fault_w), 32'd1);
    chk("g2r_code", 32'(code_w), 32'd4);
    chk("g2r_count", 32'(count_w), 32'd1);
    run(6'b100_100, 20);
    cyc(6'b100_100, 1'b1);
    run(6'b100_100, 3);
    chk("rec3_fault", 32'(fault_w), 32'd1);
    run(6'b100_100, 1);
    chk("rec_fault", 32'(fault_w), 32'd0);
    chk("rec_code", 32'(code_w), 32'd0);
    chk("rec_lamps", 32'(lamps_w), 32'(6'b100_100));
    chk("rec_count", 32'(count_w), 32'd1);

    // Both greens for 4 cycles, then watch the flash pattern.
    run(6'b001_001, 4);
    chk("bg4_fault", 32'(fault_w), 32'd1);
    chk("bg4_code", 32'(code_w), 32'd1);
    chk("bg4_count", 32'(count_w), 32'd2);
    chk("bg4_lamps", 32'(lamps_w), 32'(6'b010_010));
    for (int k = 1; k < 20; k++) begin
      run(6'b100_100, 1);
      chk("flash", 32'(lamps_w), ((k / 8) % 2 == 0) ? 32'(6'b010_010) : 32'd0);
    end

    // Clear coinciding with a filtered static fault is ignored.
    run(6'b001_001, 4);
    cyc(6'b001_001, 1'b1);
    run(6'b100_100, 5);
    chk("clr_lost_fault", 32'(fault_w), 32'd1);
    cyc(6'b100_100, 1'b1);
    run(6'b100_100, 4);
    chk("clr2_fault", 32'(fault_w), 32'd0);
    chk("clr2_count", 32'(count_w), 32'd2);

    // Yellow of exactly MIN_YELLOW_CYCLES, then a short one.
    run(6'b001_100, 3);
    run(6'b010_100, 20);
    run(6'b100_100, 1);
    chk("y20_fault", 32'(fault_w), 32'd0);
    run(6'b001_100, 3);
    run(6'b010_100, 10);
    run(6'b100_100, 1);
    chk("y10_code", 32'(code_w), 32'd5);
    chk("y10_count", 32'(count_w), 32'd3);

    // Dark main road while recovering.
    cyc(6'b100_100, 1'b1);
    run(6'b000_100, 4);
    chk("dark_fault", 32'(fault_w), 32'd1);
    chk("dark_code", 32'(code_w), 32'd2);
    chk("dark_count", 32'(count_w), 32'd4);

    // Drive the entry counter into saturation.
    repeat (255) begin
      cyc(6'b100_100, 1'b1);
      run(6'b000_100, 4);
    end
    chk("sat_count", 32'(count_w), 32'd255);

    // Asynchronous reset in the middle of the flash.
    run(6'b100_100, 3);
    rst = 1'b1;
    #2;
    model_reset();
    check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;

    // Randomized segments with occasional operator clears.
    repeat (200) begin
      pat = ($urandom_range(0, 7) == 0) ? 6'($urandom) : pats[$urandom_range(0, 9)];
      repeat ($urandom_range(1, 25)) cyc(pat, ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
